s9234_jtag_top: RTL and testbench
=================================

Name: s9234_jtag_top

Overview:
IEEE 1149.1-style JTAG wrapper around the ISCAS89 s9234 core. It contains the TAP controller, a 2-bit instruction register, a 75-cell boundary-scan register (36 input cells, 39 output cells), a bypass bit and a TDO mux. It also gives access to the core's 211-bit internal scan chain. The core netlist is an existing sub-module and is not part of this block's RTL.

Parameters:
IR_W, 2, instruction register width.
N_IN, 36, number of core primary inputs (boundary input cells).
N_OUT, 39, number of core primary outputs (boundary output cells).
N_INT, 211, internal scan chain length of the core.

Ports:
TCLK  in  1  single clock for all wrapper state (TAP, IR, BSR, bypass); rising edge.
TRST  in  1  reset; synchronous, active-high.
TMS  in  1  TAP mode select, sampled on TCLK rising edge.
TDI  in  1  serial data in.
TDO  out  1  serial data out.
CK  in  1  functional core clock; not used by wrapper logic.
g89,g94,g98,g102,g107,g301,g306,g310,g314,g319,g557..g564,g705,g639,g567,g45,g42,g39,g702,g32,g38,g46,g36,g47,g40,g37,g41,g22,g44,g23  in  1 each  core primary inputs; 36 total, listed in boundary-chain order.
g2584,g3222,g3600,g4307,g4321,g4422,g4809,g5137,g5468,g5469,g5692,g6282,g6284,g6360,g6362,g6364,g6366,g6368,g6370,g6372,g6374,g6728,g1290,g4121,g4108,g4106,g4103,g1293,g4099,g4102,g4109,g4100,g4112,g4105,g4101,g4110,g4104,g4107,g4098  out  1 each  core primary outputs; 39 total, listed in chain order.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - TRST=1 at a TCLK edge forces the following: TAP to Test-Logic-Reset, IR=11 (BYPASS), all BSR shift and update cells to 0, bypass bit to 0.
  - Five consecutive TMS=1 edges also reach Test-Logic-Reset. In that state IR is reloaded to 11.
- TAP FSM:
  - Standard 16 states, transitions on TMS at each TCLK edge.
  - States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Instruction register:
  - CapIR loads 2'b01.
  - ShIR shifts TDI into the MSB; the LSB goes to TDO.
  - UpdIR copies the shift stage to the active instruction.
  - Instruction codes:
    - 00 EXTEST: BSR selected, boundary drives core and pins.
    - 01 INTSCAN: internal chain selected.
    - 10 SAMPLE: BSR selected, normal mode.
    - 11 BYPASS: 1-bit bypass selected.
- BSR chain order: TDI -> g89 cell ... g23 cell -> g2584 cell ... g4098 cell -> TDO.
- BSR operation:
  - Each cell has a shift flop and an update latch (flop on TCLK).
  - CapDR: input cells capture the pin values; output cells capture the core outputs.
  - ShDR: shift by one toward TDO.
  - UpdDR: shift flops copy to the update flops.
  - Shift, capture and update apply only when the BSR is selected.
- Mode mux:
  - With EXTEST active, core inputs come from the input-cell update flops and output pins come from the output-cell update flops.
  - Otherwise core inputs are the pins and output pins are the core outputs (transparent).
- INTSCAN:
  - Core scan_en=1 while the TAP is in ShDR.
  - Core scan_in=TDI, and TDO=core scan_out.
  - The core clock is CK, except that TCLK is selected while INTSCAN is active; the clock mux is inside the core wrapper sub-module.
- Bypass: CapDR loads 0; ShDR shifts TDI in.
- TDO:
  - Combinational from the LSB/last stage of the selected register.
  - During ShIR it is the IR shift LSB; during ShDR it is the selected DR last stage.
  - Otherwise it is 0.
- Latency: a bit presented on TDI during ShDR appears at TDO after chain-length edges (75 for BSR, 1 for bypass, 211 for INTSCAN).
- TRST asserted mid-shift aborts the shift: update flops clear, and outputs follow the transparent path (IR=BYPASS).

Decomposition:
- Shared package: TAP state enum (16 states), IR opcode constants (EXTEST, INTSCAN, SAMPLE, BYPASS), N_IN/N_OUT/N_INT.
- One natural sub-module: bsr_cell (shift flop, update flop, capture/shift mux, mode mux), instantiated 75 times.
- The TAP FSM stays inline.

Test Plan:
- Reset: TRST=1 for one TCLK edge, then TMS=1,1,1,0 -> TAP in RTI, IR=11; with all pins 0 the outputs equal the core outputs.
- IR load: shift 2'b00 via SelDR, SelIR, CapIR, ShIR, Ex1IR, UpdIR -> active IR=00; the captured value 01 emerges on TDO during the shift.
- Bypass: IR=11, shift pattern 1,0,1,1 -> TDO gives the same pattern delayed by one TCLK.
- EXTEST drive: IR=00, shift 75 bits so g89 cell=1 and all others 0, then UpdDR -> core input g89 is 1 while pin g89=0; pin outputs equal the output update flops (all 0).
- Capture: IR=10, set pins g23=1 and g22=1, CapDR then shift 75 -> bits at chain positions of g22 and g23 read 1, and the output positions match the core responses.
- INTSCAN: IR=01, shift 211 ones then 211 zeros -> TDO shows 211 ones after a 211-cycle delay; TRST asserted mid-shift returns IR to 11.

Source files
------------

// File: rtl/s9234_jtag_top_pkg.sv
// Shared definitions for the s9234 JTAG wrapper: chain sizes, TAP states,
// instruction opcodes.
package s9234_jtag_top_pkg;

    localparam int unsigned IR_W  = 2;
    localparam int unsigned N_IN  = 36;
    localparam int unsigned N_OUT = 39;
    localparam int unsigned N_INT = 211;
    localparam int unsigned N_BSR = N_IN + N_OUT;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SH_DR,
        TAP_EX1_DR,
        TAP_PAUSE_DR,
        TAP_EX2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SH_IR,
        TAP_EX1_IR,
        TAP_PAUSE_IR,
        TAP_EX2_IR,
        TAP_UPD_IR
    } tap_state_t;

    localparam logic [IR_W-1:0] OP_EXTEST  = 2'b00;
    localparam logic [IR_W-1:0] OP_INTSCAN = 2'b01;
    localparam logic [IR_W-1:0] OP_SAMPLE  = 2'b10;
    localparam logic [IR_W-1:0] OP_BYPASS  = 2'b11;
    localparam logic [IR_W-1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/s9234_core.sv
// Behavioural stand-in for the s9234 core wrapper: core clock mux
// (CK, or TCLK while internal scan is selected), the 211-bit internal scan
// chain and a simple combinational input-to-output response.
// Ports: ck, tclk, test_sel, scan_en, scan_in, core_in -> scan_out, core_out.
module s9234_core
    import s9234_jtag_top_pkg::*;
(
    input  logic             ck,
    input  logic             tclk,
    input  logic             test_sel,
    input  logic             scan_en,
    input  logic             scan_in,
    input  logic [N_IN-1:0]  core_in,
    output logic             scan_out,
    output logic [N_OUT-1:0] core_out
);

    logic             core_clk;
    logic [N_INT-1:0] chain;

    assign core_clk = test_sel ? tclk : ck;

    // Internal chain shifts toward scan_out; holds when not scanning.
    always_ff @(posedge core_clk) begin
        if (scan_en)
            chain <= {chain[N_INT-2:0], scan_in};
    end

    assign scan_out = chain[N_INT-1];

    // Output j follows input (j mod 36), inverted on odd outputs.
    for (genvar j = 0; j < N_OUT; j++) begin : g_resp
        assign core_out[j] = core_in[j % N_IN] ^ 1'(j % 2);
    end

endmodule

// File: rtl/s9234_jtag_top_bsr_cell.sv
// One boundary-scan cell: capture/shift flop, update flop, mode mux.
// Ports: clk/rst, capture/shift/update enables, mode (1 = drive from update
// flop), data_in (pin or core output), scan_in/scan_out, data_out.
module s9234_jtag_top_bsr_cell (
    input  logic clk,
    input  logic rst,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic mode,
    input  logic data_in,
    input  logic scan_in,
    output logic scan_out,
    output logic data_out
);

    logic shift_q;
    logic upd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            if (capture)
                shift_q <= data_in;
            else if (shift)
                shift_q <= scan_in;
            if (update)
                upd_q <= shift_q;
        end
    end

    assign scan_out = shift_q;
    assign data_out = mode ? upd_q : data_in;

endmodule

// File: rtl/s9234_jtag_top.sv
// JTAG wrapper for the s9234 core: TAP controller, 2-bit IR, 75-cell BSR,
// bypass bit, internal scan access and TDO mux.
// Ports: TCLK/TRST (sync active-high), TMS, TDI, TDO, CK (core clock),
// 36 core input pins g89..g23, 39 core output pins g2584..g4098.
module s9234_jtag_top
    import s9234_jtag_top_pkg::*;
(
    input  logic TCLK,
    input  logic TRST,
    input  logic TMS,
    input  logic TDI,
    output logic TDO,
    input  logic CK,
    input  logic g89, g94, g98, g102, g107, g301, g306, g310, g314, g319,
    input  logic g557, g558, g559, g560, g561, g562, g563, g564,
    input  logic g705, g639, g567, g45, g42, g39, g702, g32, g38, g46,
    input  logic g36, g47, g40, g37, g41, g22, g44, g23,
    output logic g2584, g3222, g3600, g4307, g4321, g4422, g4809, g5137,
    output logic g5468, g5469, g5692, g6282, g6284, g6360, g6362, g6364,
    output logic g6366, g6368, g6370, g6372, g6374, g6728, g1290, g4121,
    output logic g4108, g4106, g4103, g1293, g4099, g4102, g4109, g4100,
    output logic g4112, g4105, g4101, g4110, g4104, g4107, g4098
);

    tap_state_t       state;
    logic [IR_W-1:0]  ir;
    logic [IR_W-1:0]  ir_sr;
    logic             bypass_q;
    logic [N_IN-1:0]  pin_in;
    logic [N_IN-1:0]  core_in;
    logic [N_OUT-1:0] core_out;
    logic [N_OUT-1:0] pin_out;
    logic [N_BSR-1:0] bsr_so;
    logic [N_BSR-1:0] bsr_si;
    logic             bsr_sel, mode, cap_en, sh_en, upd_en;
    logic             intscan, scan_en, scan_out;

    // Bit 0 is the cell nearest TDI.
    assign pin_in = {g23, g44, g22, g41, g37, g40, g47, g36, g46, g38,
                     g32, g702, g39, g42, g45, g567, g639, g705, g564, g563,
                     g562, g561, g560, g559, g558, g557, g319, g314, g310, g306,
                     g301, g107, g102, g98, g94, g89};

    assign {g4098, g4107, g4104, g4110, g4101, g4105, g4112, g4100, g4109, g4102,
            g4099, g1293, g4103, g4106, g4108, g4121, g1290, g6728, g6374, g6372,
            g6370, g6368, g6366, g6364, g6362, g6360, g6284, g6282, g5692, g5469,
            g5468, g5137, g4809, g4422, g4321, g4307, g3600, g3222, g2584} = pin_out;

    // TAP controller.
    always_ff @(posedge TCLK) begin
        if (TRST) begin
            state <= TAP_TLR;
        end else begin
            case (state)
                TAP_TLR:      state <= TMS ? TAP_TLR      : TAP_RTI;
                TAP_RTI:      state <= TMS ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:   state <= TMS ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   state <= TMS ? TAP_EX1_DR   : TAP_SH_DR;
                TAP_SH_DR:    state <= TMS ? TAP_EX1_DR   : TAP_SH_DR;
                TAP_EX1_DR:   state <= TMS ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state <= TMS ? TAP_EX2_DR   : TAP_PAUSE_DR;
                TAP_EX2_DR:   state <= TMS ? TAP_UPD_DR   : TAP_SH_DR;
                TAP_UPD_DR:   state <= TMS ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:   state <= TMS ? TAP_TLR      : TAP_CAP_IR;
                TAP_CAP_IR:   state <= TMS ? TAP_EX1_IR   : TAP_SH_IR;
                TAP_SH_IR:    state <= TMS ? TAP_EX1_IR   : TAP_SH_IR;
                TAP_EX1_IR:   state <= TMS ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state <= TMS ? TAP_EX2_IR   : TAP_PAUSE_IR;
                TAP_EX2_IR:   state <= TMS ? TAP_UPD_IR   : TAP_SH_IR;
                TAP_UPD_IR:   state <= TMS ? TAP_SEL_DR   : TAP_RTI;
                default:      state <= TAP_TLR;
            endcase
        end
    end

    // Instruction register; Test-Logic-Reset keeps BYPASS loaded.
    always_ff @(posedge TCLK) begin
        if (TRST || state == TAP_TLR) begin
            ir    <= OP_BYPASS;
            ir_sr <= IR_CAPTURE;
        end else begin
            case (state)
                TAP_CAP_IR: ir_sr <= IR_CAPTURE;
                TAP_SH_IR:  ir_sr <= {TDI, ir_sr[IR_W-1:1]};
                TAP_UPD_IR: ir    <= ir_sr;
                default:    ;
            endcase
        end
    end

    // Bypass bit.
    always_ff @(posedge TCLK) begin
        if (TRST)
            bypass_q <= 1'b0;
        else if (ir == OP_BYPASS) begin
            if (state == TAP_CAP_DR)
                bypass_q <= 1'b0;
            else if (state == TAP_SH_DR)
                bypass_q <= TDI;
        end
    end

    assign bsr_sel = (ir == OP_EXTEST) || (ir == OP_SAMPLE);
    assign mode    = (ir == OP_EXTEST);
    assign cap_en  = bsr_sel && (state == TAP_CAP_DR);
    assign sh_en   = bsr_sel && (state == TAP_SH_DR);
    assign upd_en  = bsr_sel && (state == TAP_UPD_DR);
    assign intscan = (ir == OP_INTSCAN);
    assign scan_en = (state == TAP_SH_DR);
    assign bsr_si  = {bsr_so[N_BSR-2:0], TDI};

    // Input cells sit between pins and core, output cells between core and pins.
    for (genvar k = 0; k < N_BSR; k++) begin : g_bsr
        logic din;
        logic dout;
        if (k < N_IN) begin : g_in
            assign din        = pin_in[k];
            assign core_in[k] = dout;
        end else begin : g_out
            assign din               = core_out[k - N_IN];
            assign pin_out[k - N_IN] = dout;
        end
        s9234_jtag_top_bsr_cell u_cell (
            .clk      (TCLK),
            .rst      (TRST),
            .capture  (cap_en),
            .shift    (sh_en),
            .update   (upd_en),
            .mode     (mode),
            .data_in  (din),
            .scan_in  (bsr_si[k]),
            .scan_out (bsr_so[k]),
            .data_out (dout)
        );
    end

    s9234_core u_core (
        .ck       (CK),
        .tclk     (TCLK),
        .test_sel (intscan),
        .scan_en  (scan_en),
        .scan_in  (TDI),
        .core_in  (core_in),
        .scan_out (scan_out),
        .core_out (core_out)
    );

    // TDO mux: last stage of the register being shifted, else 0.
    always_comb begin
        TDO = 1'b0;
        if (state == TAP_SH_IR) begin
            TDO = ir_sr[0];
        end else if (state == TAP_SH_DR) begin
            case (ir)
                OP_EXTEST, OP_SAMPLE: TDO = bsr_so[N_BSR-1];
                OP_INTSCAN:           TDO = scan_out;
                default:              TDO = bypass_q;
            endcase
        end
    end

endmodule

// File: tb/tb_s9234_jtag_top.sv
// Directed bench for s9234_jtag_top: reset, IR load, bypass, EXTEST drive,
// SAMPLE capture, internal scan latency and TRST abort.
module tb_s9234_jtag_top;

    logic        TCLK, TRST, TMS, TDI, TDO, CK;
    logic [35:0] pin;
    logic [38:0] pout;
    int          errors;
    int          checks;

    s9234_jtag_top dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .CK(CK),
        .g89(pin[0]),   .g94(pin[1]),   .g98(pin[2]),   .g102(pin[3]),  .g107(pin[4]),
        .g301(pin[5]),  .g306(pin[6]),  .g310(pin[7]),  .g314(pin[8]),  .g319(pin[9]),
        .g557(pin[10]), .g558(pin[11]), .g559(pin[12]), .g560(pin[13]), .g561(pin[14]),
        .g562(pin[15]), .g563(pin[16]), .g564(pin[17]), .g705(pin[18]), .g639(pin[19]),
        .g567(pin[20]), .g45(pin[21]),  .g42(pin[22]),  .g39(pin[23]),  .g702(pin[24]),
        .g32(pin[25]),  .g38(pin[26]),  .g46(pin[27]),  .g36(pin[28]),  .g47(pin[29]),
        .g40(pin[30]),  .g37(pin[31]),  .g41(pin[32]),  .g22(pin[33]),  .g44(pin[34]),
        .g23(pin[35]),
        .g2584(pout[0]),  .g3222(pout[1]),  .g3600(pout[2]),  .g4307(pout[3]),
        .g4321(pout[4]),  .g4422(pout[5]),  .g4809(pout[6]),  .g5137(pout[7]),
        .g5468(pout[8]),  .g5469(pout[9]),  .g5692(pout[10]), .g6282(pout[11]),
        .g6284(pout[12]), .g6360(pout[13]), .g6362(pout[14]), .g6364(pout[15]),
        .g6366(pout[16]), .g6368(pout[17]), .g6370(pout[18]), .g6372(pout[19]),
        .g6374(pout[20]), .g6728(pout[21]), .g1290(pout[22]), .g4121(pout[23]),
        .g4108(pout[24]), .g4106(pout[25]), .g4103(pout[26]), .g1293(pout[27]),
        .g4099(pout[28]), .g4102(pout[29]), .g4109(pout[30]), .g4100(pout[31]),
        .g4112(pout[32]), .g4105(pout[33]), .g4101(pout[34]), .g4110(pout[35]),
        .g4104(pout[36]), .g4107(pout[37]), .g4098(pout[38])
    );

    initial TCLK = 1'b0;
    always #5 TCLK = ~TCLK;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply TMS/TDI, take one rising edge, settle 1 time unit after it.
    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        #1;
    endtask

    // Core response of the stand-in: out[j] = in[j mod 36] ^ (j odd).
    function automatic logic [38:0] core_resp(input logic [35:0] ci);
        logic [38:0] r;
        for (int j = 0; j < 39; j++) r[j] = ci[j % 36] ^ 1'(j % 2);
        return r;
    endfunction

    // Order in which captured cells appear on TDO (cell 74 first).
    function automatic logic [79:0] read_order(input logic [74:0] cap);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 75; i++) r[i] = cap[74 - i];
        return r;
    endfunction

    // From RTI: load an instruction, return bits seen on TDO during the shift.
    task automatic load_ir(input logic [1:0] op, output logic [1:0] seen);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        seen[0] = TDO;
        tick(1'b0, op[0]);
        seen[1] = TDO;
        tick(1'b1, op[1]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From RTI: capture, shift n bits of din (bit 0 first), update, back to RTI.
    task automatic shift_dr(input logic [79:0] din, input int n, output logic [79:0] rd);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rd = '0;
        for (int i = 0; i < n; i++) begin
            rd[i] = TDO;
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    logic [1:0]  seen;
    logic [79:0] rd;
    logic [79:0] din;
    logic [35:0] ci;
    int          ones;
    int          bad;

    initial begin
        errors = 0;
        checks = 0;
        TRST = 1'b1;
        TMS  = 1'b1;
        TDI  = 1'b0;
        CK   = 1'b0;
        pin  = '0;

        // Reset and walk to RTI.
        tick(1'b0, 1'b0);
        TRST = 1'b0;
        check("tlr_tdo", 80'(TDO), 80'(0));
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("reset_pins", 80'(pout), 80'(39'h2A_AAAA_AAAA));

        // Load EXTEST; capture value 01 comes out LSB first.
        load_ir(2'b00, seen);
        check("ir_capture", 80'(seen), 80'(2'b01));
        check("extest_pins_zero", 80'(pout), 80'(0));

        // Put 1 into the g89 cell only (last bit shifted lands in cell 0).
        din = '0;
        din[74] = 1'b1;
        shift_dr(din, 75, rd);
        check("extest_first_capture", rd, read_order({core_resp(36'h0), 36'h0}));
        check("extest_pins_after_upd", 80'(pout), 80'(0));

        // Core now sees g89=1 while pin g89=0; observe via capture.
        ci = 36'h1;
        shift_dr(80'h0, 75, rd);
        check("extest_core_drive", rd, read_order({core_resp(ci), 36'h0}));

        // Bypass: one-cycle delay, captured 0 first.
        load_ir(2'b11, seen);
        shift_dr(80'(5'b01101), 5, rd);
        check("bypass_delay", rd, 80'(5'b11010));

        // SAMPLE with g22 and g23 high.
        pin[33] = 1'b1;
        pin[35] = 1'b1;
        load_ir(2'b10, seen);
        check("sample_pins", 80'(pout), 80'(core_resp(pin)));
        shift_dr(80'h0, 75, rd);
        check("sample_capture", rd, read_order({core_resp(pin), pin}));
        check("sample_g22", 80'(rd[41]), 80'(1));
        check("sample_g23", 80'(rd[39]), 80'(1));
        pin = '0;

        // Internal scan: 211 ones then zeros, 211-cycle latency.
        load_ir(2'b01, seen);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        ones = 0;
        bad  = 0;
        for (int n = 0; n < 432; n++) begin
            if (n >= 211 && n < 422 && TDO === 1'b1) ones++;
            if (n >= 422 && TDO !== 1'b0) bad++;
            tick(1'b0, n < 211);
        end
        check("intscan_ones", 80'(ones), 80'(211));
        check("intscan_zero_tail", 80'(bad), 80'(0));

        // TRST in the middle of the scan shift.
        TRST = 1'b1;
        tick(1'b0, 1'b0);
        TRST = 1'b0;
        check("trst_tdo", 80'(TDO), 80'(0));
        check("trst_pins", 80'(pout), 80'(39'h2A_AAAA_AAAA));
        tick(1'b0, 1'b0);
        shift_dr(80'(5'b01101), 5, rd);
        check("trst_bypass", rd, 80'(5'b11010));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
